bus_sram_slave: RTL and testbench



---
 rtl/bus_sram_slave.sv | 190 +++++++++++++++++++
 tb/tb_bus_sram_slave.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_sram_slave.sv
// AHB-lite style single-port SRAM responder with configurable wait states and a two-cycle ERROR response.
// Optional feature macro: BUS_SRAM_MISALIGN_ERR_EN (misaligned halfword/word transfers answer ERROR instead of being aligned).
module bus_sram_slave #(
    parameter int DWidth     = 32,
    parameter int AWidth     = 32,
    parameter int Depth      = 1024,
    parameter int WinWidth   = 16,
    parameter int WaitStates = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sel_i,
    input  logic [AWidth-1:0] addr_i,
    input  logic [1:0]        trans_i,
    input  logic              write_i,
    input  logic [2:0]        size_i,
    input  logic [DWidth-1:0] wdata_i,
    input  logic              ready_i,
    output logic [DWidth-1:0] rdata_o,
    output logic              resp_o,
    output logic              readyout_o
);

    localparam int IdxW = $clog2(Depth);
    localparam int LoW  = IdxW + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            3'b000:  strb = 4'b0001 << lo;
            3'b001:  strb = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0]     mem_q [Depth];
    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;
    logic [LoW-1:0]  addr_q, addr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            readyout_q, readyout_d;
    logic            resp_q, resp_d;

    logic            accept_s;
    logic            err_s;
    logic            mis_s;
    logic            commit_s;
    logic [LoW-1:0]  addr_lo_s;
    logic [31:0]     rd_word_s;
    logic            unused_s;

    assign unused_s = ^addr_i[AWidth-1:WinWidth];

    // Address-phase decode, hazard forwarding and FSM next-state/output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        write_d    = write_q;
        size_d     = size_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        addr_lo_s  = addr_i[LoW-1:0];
        mis_s      = 1'b0;
`ifdef BUS_SRAM_MISALIGN_ERR_EN
        mis_s = ((size_i == 3'b001) && addr_i[0]) || ((size_i == 3'b010) && (addr_i[1:0] != 2'b00));
`else
        if (size_i == 3'b001) begin
            addr_lo_s[0] = 1'b0;
        end else if (size_i == 3'b010) begin
            addr_lo_s[1:0] = 2'b00;
        end else begin
            addr_lo_s = addr_i[LoW-1:0];
        end
`endif
        err_s    = (size_i > 3'b010) || (addr_i[WinWidth-1:LoW] != '0) || mis_s;
        accept_s = sel_i && ready_i && trans_i[1] && readyout_q;
        commit_s = (state_q == ST_IDLE) && pend_q && write_q;

        // A write finishing on this edge must be visible to a read captured on the same edge.
        rd_word_s = mem_q[addr_lo_s[LoW-1:2]];
        if (commit_s && (addr_q[LoW-1:2] == addr_lo_s[LoW-1:2])) begin
            rd_word_s = merge_bytes(rd_word_s, wdata_i, lane_strobe(size_q, addr_q[1:0]));
        end else begin
            rd_word_s = mem_q[addr_lo_s[LoW-1:2]];
        end

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                if (accept_s && err_s) begin
                    state_d = ST_ERR1;
                end else if (accept_s) begin
                    pend_d  = 1'b1;
                    addr_d  = addr_lo_s;
                    write_d = write_i;
                    size_d  = size_i;
                    if (WaitStates == 0) begin
                        rdata_d = write_i ? rdata_q : rd_word_s;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WaitStates);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    rdata_d = write_q ? rdata_q : mem_q[addr_q[LoW-1:2]];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase

        readyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        resp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // Control and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            pend_q     <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= 3'b000;
            addr_q     <= '0;
            rdata_q    <= 32'h0000_0000;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            write_q    <= write_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            readyout_q <= readyout_d;
            resp_q     <= resp_d;
        end
    end

    // Word array, deliberately not reset; written at the end of the final OKAY write data phase.
    always_ff @(posedge clk_i) begin
        if (commit_s) begin
            mem_q[addr_q[LoW-1:2]] <= merge_bytes(mem_q[addr_q[LoW-1:2]], wdata_i,
                                                  lane_strobe(size_q, addr_q[1:0]));
        end
    end

    assign rdata_o    = rdata_q;
    assign resp_o     = resp_q;
    assign readyout_o = readyout_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: zero-wait instance driven from a vector table,
// two-wait instance exercised by hand-written stall and reset-abort sequences.
module tb_bus_sram_slave;

    logic        clk;
    logic        rst_n;
    logic        sel0, sel2;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        rdy0, rdy2;
    logic        resp0, resp2;
    logic [31:0] rdata0, rdata2;

    int total = 0;
    int bad   = 0;

`ifdef BUS_SRAM_MISALIGN_ERR_EN
    localparam bit Mis = 1'b1;
`else
    localparam bit Mis = 1'b0;
`endif

    bus_sram_slave #(.WaitStates(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel0), .addr_i(addr), .trans_i(trans),
        .write_i(wr), .size_i(size), .wdata_i(wdata), .ready_i(rdy0),
        .rdata_o(rdata0), .resp_o(resp0), .readyout_o(rdy0)
    );

    bus_sram_slave #(.WaitStates(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel2), .addr_i(addr), .trans_i(trans),
        .write_i(wr), .size_i(size), .wdata_i(wdata), .ready_i(rdy2),
        .rdata_o(rdata2), .resp_o(resp2), .readyout_o(rdy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic        exp_resp;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    function automatic vec_t mk(input logic s, input logic [1:0] t, input logic w, input logic [2:0] z,
                                input logic [31:0] a, input logic [31:0] d, input logic er,
                                input logic ep, input logic cr, input logic [31:0] ed);
        vec_t v;
        v.sel = s; v.trans = t; v.wr = w; v.size = z; v.addr = a; v.wdata = d;
        v.exp_rdy = er; v.exp_resp = ep; v.chk_rd = cr; v.exp_rd = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        while (rdy2 !== 1'b1 && n < 10) begin
            n++;
            tick();
        end
    endtask

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    logic [31:0] after_mis;
    int          n;

    initial begin
        after_mis = Mis ? 32'h1234_BEEF : 32'h5566_7788;
        vt[0]  = mk(1'b0, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0);
        vt[1]  = mk(1'b1, NSQ, 1'b1, SW, 32'h10, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0);
        vt[2]  = mk(1'b1, NSQ, 1'b0, SW, 32'h10, 32'hDEADBEEF,  1'b1, 1'b0, 1'b0, 32'h0);
        vt[3]  = mk(1'b1, NSQ, 1'b1, SB, 32'h13, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        vt[4]  = mk(1'b1, NSQ, 1'b0, SW, 32'h10, 32'hAA000000,  1'b1, 1'b0, 1'b0, 32'h0);
        vt[5]  = mk(1'b1, NSQ, 1'b1, SH, 32'h12, 32'h0,         1'b1, 1'b0, 1'b1, 32'hAAADBEEF);
        vt[6]  = mk(1'b1, NSQ, 1'b0, SW, 32'h10, 32'h12340000,  1'b1, 1'b0, 1'b0, 32'h0);
        vt[7]  = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h1234BEEF);
        vt[8]  = mk(1'b1, NSQ, 1'b0, SW, 32'h1000, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0);
        vt[9]  = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0);
        vt[10] = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0);
        vt[11] = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h1234BEEF);
        vt[12] = mk(1'b1, NSQ, 1'b0, 3'b011, 32'h10, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0);
        vt[13] = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0);
        vt[14] = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0);
        vt[15] = mk(1'b1, NSQ, 1'b1, SW, 32'h11, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0);
        vt[16] = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h55667788,   !Mis, Mis,  1'b0, 32'h0);
        vt[17] = mk(1'b1, NSQ, 1'b0, SW, 32'h10, 32'h0,         1'b1, Mis,  1'b0, 32'h0);
        vt[18] = mk(1'b1, BSY, 1'b1, SW, 32'h10, 32'h0,         1'b1, 1'b0, 1'b1, after_mis);
        vt[19] = mk(1'b0, NSQ, 1'b1, SW, 32'h10, 32'hFFFFFFFF,  1'b1, 1'b0, 1'b0, 32'h0);
        vt[20] = mk(1'b1, NSQ, 1'b0, SW, 32'h10, 32'hFFFFFFFF,  1'b1, 1'b0, 1'b0, 32'h0);
        vt[21] = mk(1'b1, IDL, 1'b0, SW, 32'h0, 32'h0,          1'b1, 1'b0, 1'b1, after_mis);

        rst_n = 1'b0; sel0 = 1'b0; sel2 = 1'b0; addr = 32'h0; trans = IDL;
        wr = 1'b0; size = SW; wdata = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_rdy2", {31'd0, rdy2}, 32'd1);
        chk("rst_resp2", {31'd0, resp2}, 32'd0);
        chk("rst_rdata2", rdata2, 32'h0);

        for (int i = 0; i < NV; i++) begin
            sel0 = vt[i].sel; trans = vt[i].trans; wr = vt[i].wr;
            size = vt[i].size; addr = vt[i].addr; wdata = vt[i].wdata;
            chk($sformatf("v%0d_rdy", i), {31'd0, rdy0}, {31'd0, vt[i].exp_rdy});
            chk($sformatf("v%0d_resp", i), {31'd0, resp0}, {31'd0, vt[i].exp_resp});
            if (vt[i].chk_rd) begin
                chk($sformatf("v%0d_rdata", i), rdata0, vt[i].exp_rd);
            end
            tick();
        end
        sel0 = 1'b0; trans = IDL;

        // Two-wait instance: write then read with stall counting.
        sel2 = 1'b1; trans = NSQ; wr = 1'b1; size = SW; addr = 32'h10;
        tick();
        trans = IDL; wdata = 32'hDEADBEEF;
        count_stall(n);
        chk("w2_write_stall", 32'(n), 32'd2);
        chk("w2_write_resp", {31'd0, resp2}, 32'd0);
        trans = NSQ; wr = 1'b0; addr = 32'h10;
        tick();
        trans = IDL;
        count_stall(n);
        chk("w2_read_stall", 32'(n), 32'd2);
        chk("w2_read_resp", {31'd0, resp2}, 32'd0);
        chk("w2_read_data", rdata2, 32'hDEADBEEF);
        tick();

        // Reset asserted in the middle of a waited write.
        trans = NSQ; wr = 1'b1; addr = 32'h10;
        tick();
        trans = IDL; wdata = 32'h11111111;
        chk("w2_abort_wait", {31'd0, rdy2}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rdy", {31'd0, rdy2}, 32'd1);
        chk("abort_resp", {31'd0, resp2}, 32'd0);
        chk("abort_rdata2", rdata2, 32'h0);
        chk("abort_rdata0", rdata0, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        trans = NSQ; wr = 1'b0; addr = 32'h10;
        tick();
        trans = IDL;
        count_stall(n);
        chk("abort_read_stall", 32'(n), 32'd2);
        chk("abort_read_data", rdata2, 32'hDEADBEEF);
        sel2 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
